// File: rtl/spi_reg_slave.sv
// SPI slave that oversamples the SPI pins in the clk domain and turns each frame
// (command byte {addr, opcode} then one DATA_W-bit word) into single-cycle register strobes.
module spi_reg_slave #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 16,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic [3:0]        reg_addr,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              frame_err
);
    localparam int         CNT_W    = $clog2(DATA_W + 1);
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

    logic sclk_meta_reg, sclk_sync_reg, sclk_dly_reg;
    logic mosi_meta_reg, mosi_sync_reg;
    logic cs_meta_reg, cs_sync_reg, cs_dly_reg;
    logic armed_reg;

    // cs_n flops reset low and armed_reg stays clear until cs_n is seen high, so a
    // reset released in the middle of a frame cannot fake a cs_n falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_reg <= CPOL;
            sclk_sync_reg <= CPOL;
            sclk_dly_reg  <= CPOL;
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
            cs_meta_reg   <= 1'b0;
            cs_sync_reg   <= 1'b0;
            cs_dly_reg    <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            sclk_meta_reg <= sclk;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_dly_reg  <= sclk_sync_reg;
            mosi_meta_reg <= mosi;
            mosi_sync_reg <= mosi_meta_reg;
            cs_meta_reg   <= cs_n;
            cs_sync_reg   <= cs_meta_reg;
            cs_dly_reg    <= cs_sync_reg;
            armed_reg     <= armed_reg | cs_sync_reg;
        end
    end

    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_rise, cs_fall;

    assign sclk_edge   = sclk_sync_reg ^ sclk_dly_reg;
    assign lead_edge   = sclk_edge & (sclk_sync_reg != CPOL);
    assign trail_edge  = sclk_edge & (sclk_sync_reg == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_rise     = cs_sync_reg & ~cs_dly_reg;
    assign cs_fall     = armed_reg & ~cs_sync_reg & cs_dly_reg;
    assign busy        = armed_reg & ~cs_sync_reg;

    state_t             state_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [6:0]         cmd_sr_reg;
    logic [3:0]         addr_reg;
    logic [DATA_W-2:0]  rx_sr_reg;
    logic [DATA_W-1:0]  tx_sr_reg;
    logic               miso_reg;
    logic [3:0]         reg_addr_reg;
    logic               reg_wr_reg;
    logic [DATA_W-1:0]  reg_wdata_reg;
    logic               reg_rd_reg;
    logic               frame_err_reg;

    logic [7:0]        cmd_next;
    logic [DATA_W-1:0] rx_next;
    logic              cmd_legal;

    assign cmd_next  = {cmd_sr_reg, mosi_sync_reg};
    assign rx_next   = {rx_sr_reg, mosi_sync_reg};
    assign cmd_legal = ((cmd_next[3:0] == OP_WRITE) || (cmd_next[3:0] == OP_READ)) &&
                       ({1'b0, cmd_next[7:4]} < 5'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            cmd_sr_reg    <= '0;
            addr_reg      <= '0;
            rx_sr_reg     <= '0;
            tx_sr_reg     <= '0;
            miso_reg      <= 1'b0;
            reg_addr_reg  <= '0;
            reg_wr_reg    <= 1'b0;
            reg_wdata_reg <= '0;
            reg_rd_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            reg_wr_reg    <= 1'b0;
            reg_rd_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            // Read data is valid the cycle after the request.
            if (reg_rd_reg) begin
                tx_sr_reg <= reg_rdata;
            end
            if (cs_rise) begin
                if ((state_reg == CMD && bit_cnt_reg != '0) ||
                    state_reg == WDATA || state_reg == RDATA) begin
                    frame_err_reg <= 1'b1;
                end
                state_reg <= IDLE;
                miso_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (cs_fall) begin
                            state_reg   <= CMD;
                            bit_cnt_reg <= '0;
                        end
                    end
                    CMD: begin
                        if (sample_edge) begin
                            cmd_sr_reg <= cmd_next[6:0];
                            if (bit_cnt_reg == CNT_W'(7)) begin
                                bit_cnt_reg <= '0;
                                addr_reg    <= cmd_next[7:4];
                                if (!cmd_legal) begin
                                    frame_err_reg <= 1'b1;
                                    state_reg     <= DONE;
                                end else if (cmd_next[3:0] == OP_WRITE) begin
                                    state_reg <= WDATA;
                                end else begin
                                    reg_rd_reg   <= 1'b1;
                                    reg_addr_reg <= cmd_next[7:4];
                                    state_reg    <= RDATA;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    WDATA: begin
                        if (sample_edge) begin
                            rx_sr_reg <= rx_next[DATA_W-2:0];
                            if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                                reg_wr_reg    <= 1'b1;
                                reg_wdata_reg <= rx_next;
                                reg_addr_reg  <= addr_reg;
                                state_reg     <= DONE;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    RDATA: begin
                        // The frame completes on the sample edge that consumes the last bit,
                        // so the final bit stays on miso until the master has taken it.
                        if (shift_edge && bit_cnt_reg != CNT_W'(DATA_W)) begin
                            miso_reg    <= tx_sr_reg[DATA_W-1];
                            tx_sr_reg   <= {tx_sr_reg[DATA_W-2:0], 1'b0};
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end else if (sample_edge && bit_cnt_reg == CNT_W'(DATA_W)) begin
                            miso_reg  <= 1'b0;
                            state_reg <= DONE;
                        end
                    end
                    DONE: begin
                        miso_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        miso_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign miso      = miso_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wr    = reg_wr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign reg_rd    = reg_rd_reg;
    assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: three instances (mode 0 / 64-bit, mode 0 / 32-bit with 8 registers,
// mode 3 / 64-bit) driven by one SPI master task; strobes are checked by a scoreboard monitor.
module tb_spi_reg_slave;
    localparam int         HALF = 5;
    localparam logic [2:0] KW   = 3'b001;
    localparam logic [2:0] KR   = 3'b010;
    localparam logic [2:0] KE   = 3'b100;

    typedef struct packed {
        logic [1:0]  dut;
        logic [2:0]  kind;
        logic [3:0]  addr;
        logic [63:0] data;
        logic [31:0] at;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mosi;
    logic [2:0]  sclk_v;
    logic [2:0]  cs_v;
    wire  [2:0]  miso_v, wr_v, rd_v, busy_v, err_v;
    wire  [3:0]  addr0, addr1, addr2;
    wire  [63:0] wdata0, wdata2;
    wire  [31:0] wdata1;
    logic [63:0] mem2 [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    ev_t         exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_slave #(.DATA_W(64), .NUM_REGS(16), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[0]), .mosi(mosi), .cs_n(cs_v[0]),
        .miso(miso_v[0]), .reg_addr(addr0), .reg_wr(wr_v[0]), .reg_wdata(wdata0),
        .reg_rd(rd_v[0]), .reg_rdata(64'h0123_4567_89AB_CDEF), .busy(busy_v[0]),
        .frame_err(err_v[0])
    );

    spi_reg_slave #(.DATA_W(32), .NUM_REGS(8), .CPOL(1'b0), .CPHA(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[1]), .mosi(mosi), .cs_n(cs_v[1]),
        .miso(miso_v[1]), .reg_addr(addr1), .reg_wr(wr_v[1]), .reg_wdata(wdata1),
        .reg_rd(rd_v[1]), .reg_rdata(32'h0), .busy(busy_v[1]), .frame_err(err_v[1])
    );

    spi_reg_slave #(.DATA_W(64), .NUM_REGS(16), .CPOL(1'b1), .CPHA(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[2]), .mosi(mosi), .cs_n(cs_v[2]),
        .miso(miso_v[2]), .reg_addr(addr2), .reg_wr(wr_v[2]), .reg_wdata(wdata2),
        .reg_rd(rd_v[2]), .reg_rdata(mem2[addr2]), .busy(busy_v[2]), .frame_err(err_v[2])
    );

    // Register file behind the mode-3 instance, so a write can be read back.
    always @(posedge clk) begin
        if (wr_v[2]) mem2[addr2] <= wdata2;
    end

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic logic [3:0] addr_of(input int d);
        case (d)
            0:       return addr0;
            1:       return addr1;
            default: return addr2;
        endcase
    endfunction

    function automatic logic [63:0] wdata_of(input int d);
        case (d)
            0:       return wdata0;
            1:       return {32'h0, wdata1};
            default: return wdata2;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: command byte then nbits data bits, MSB first. Expected strobe (if any) is
    // queued right after the pin edge that should cause it, stamped with its due cycle.
    task automatic spi_frame(input int d, input int w, input logic [7:0] cmd, input logic [63:0] data,
                             input int nbits, input bit do_end, input logic [2:0] exp_kind,
                             input logic [3:0] exp_addr, input logic [63:0] exp_data,
                             output logic [63:0] rx, output logic miso_any);
        ev_t e;
        rx = '0;
        miso_any = 1'b0;
        cs_v[d] = 1'b0;
        tick(HALF);
        for (int i = 0; i < 8 + nbits; i++) begin
            sclk_v[d] = 1'b0;
            mosi = (i < 8) ? cmd[7-i] : data[w-1-(i-8)];
            tick(HALF);
            miso_any = miso_any | miso_v[d];
            if (i >= 8) rx = {rx[62:0], miso_v[d]};
            sclk_v[d] = 1'b1;
            if (exp_kind != 3'b000 && i == ((exp_kind == KW) ? 7 + w : 7)) begin
                e.dut  = 2'(d);
                e.kind = exp_kind;
                e.addr = exp_addr;
                e.data = exp_data;
                e.at   = 32'(cyc + 3);
                exp_q.push_back(e);
            end
            tick(HALF);
        end
        if (do_end) begin
            sclk_v[d] = (d == 2);
            tick(HALF);
            cs_v[d] = 1'b1;
            tick(2 * HALF);
        end
    endtask

    always @(negedge clk) begin
        ev_t        obs;
        ev_t        e;
        logic [2:0] k;
        for (int d = 0; d < 3; d++) begin
            k = {err_v[d], rd_v[d], wr_v[d]};
            if (k != 3'b000) begin
                obs.dut  = 2'(d);
                obs.kind = k;
                obs.addr = (k == KW || k == KR) ? addr_of(d) : 4'h0;
                obs.data = (k == KW) ? wdata_of(d) : 64'h0;
                obs.at   = 32'(cyc);
                $display("cyc %0d dut%0d strobe %b addr %h data %h", cyc, d, k, obs.addr, obs.data);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", obs, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe", obs, e);
                end
            end
        end
    end

    initial begin
        logic [63:0] rx;
        logic        miso_any;
        rst_n  = 1'b0;
        sclk_v = 3'b100;
        cs_v   = 3'b111;
        mosi   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", {miso_v[0], addr0, wr_v[0], wdata0, rd_v[0], busy_v[0], err_v[0]}, '0);
        check("reset_dut1", {miso_v[1], addr1, wr_v[1], wdata1, rd_v[1], busy_v[1], err_v[1]}, '0);
        check("reset_dut2", {miso_v[2], addr2, wr_v[2], wdata2, rd_v[2], busy_v[2], err_v[2]}, '0);
        rst_n = 1'b1;
        tick(6);
        check("idle_busy", busy_v, 3'b000);

        // Mode 0, 64-bit: write all ones to register 0, then read register 3.
        spi_frame(0, 64, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, KW, 4'h0,
                  64'hFFFF_FFFF_FFFF_FFFF, rx, miso_any);
        spi_frame(0, 64, 8'h32, 64'h0, 64, 1'b1, KR, 4'h3, 64'h0, rx, miso_any);
        check("read_miso_addr3", rx, 64'h0123_4567_89AB_CDEF);

        // Write aborted after 40 data bits: one frame_err, no reg_wr, busy drops after 2 clk.
        spi_frame(0, 64, 8'h51, 64'hFEED_F00D_1234_5678, 40, 1'b0, 3'b000, 4'h0, 64'h0, rx, miso_any);
        exp_q.push_back('{dut: 2'd0, kind: KE, addr: 4'h0, data: 64'h0, at: 32'(cyc + 3)});
        cs_v[0] = 1'b1;
        tick(1);
        check("busy_hold_1clk", busy_v[0], 1'b1);
        tick(1);
        check("busy_fall_2clk", busy_v[0], 1'b0);
        tick(HALF);
        sclk_v[0] = 1'b0;
        tick(2 * HALF);

        // NUM_REGS=8: illegal opcode, out-of-range address, then the highest legal address.
        spi_frame(1, 32, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 16, 1'b1, KE, 4'h0, 64'h0, rx, miso_any);
        check("illegal_op_miso", miso_any, 1'b0);
        spi_frame(1, 32, 8'h91, 64'hFFFF_FFFF_FFFF_FFFF, 16, 1'b1, KE, 4'h0, 64'h0, rx, miso_any);
        check("illegal_addr_miso", miso_any, 1'b0);
        spi_frame(1, 32, 8'h71, 64'h0000_0000_1234_5678, 32, 1'b1, KW, 4'h7,
                  64'h0000_0000_1234_5678, rx, miso_any);

        // Mode 3: write register 2, read it back.
        spi_frame(2, 64, 8'h21, 64'hA5A5_A5A5_5A5A_5A5A, 64, 1'b1, KW, 4'h2,
                  64'hA5A5_A5A5_5A5A_5A5A, rx, miso_any);
        spi_frame(2, 64, 8'h22, 64'h0, 64, 1'b1, KR, 4'h2, 64'h0, rx, miso_any);
        check("mode3_readback", rx, 64'hA5A5_A5A5_5A5A_5A5A);

        // Reset in the middle of a write, then a clean write and a read of register 0.
        spi_frame(0, 64, 8'h61, 64'h1111_2222_3333_4444, 30, 1'b0, 3'b000, 4'h0, 64'h0, rx, miso_any);
        rst_n = 1'b0;
        #1;
        check("reset_midframe", {miso_v[0], addr0, wr_v[0], wdata0, rd_v[0], busy_v[0], err_v[0]}, '0);
        sclk_v[0] = 1'b0;
        cs_v[0]   = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        spi_frame(0, 64, 8'h71, 64'hDEAD_BEEF_CAFE_F00D, 64, 1'b1, KW, 4'h7,
                  64'hDEAD_BEEF_CAFE_F00D, rx, miso_any);
        spi_frame(0, 64, 8'h02, 64'h0, 64, 1'b1, KR, 4'h0, 64'h0, rx, miso_any);
        check("read_miso_addr0", rx, 64'h0123_4567_89AB_CDEF);

        tick(20);
        check("pending_strobes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave with a register-bus back end, the successor to the fixed 64-bit, mode-0-only SPI test port. It oversamples SCLK/MOSI/CS_N in the system clock domain and decodes an 8-bit command byte carrying an opcode and a register address. It then moves a DATA_W-bit word to or from the RTC core through single-cycle strobes. It sits between the package pins and the RTC register file.

## Interface
- DATA_W, 64, data word width in bits (8..64)
- NUM_REGS, 16, number of addressable registers (1..16); addresses >= NUM_REGS are illegal
- CPOL, 0, SCLK idle level
- CPHA, 0, 0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
- clk  in  1  system clock, must be >= 4x SCLK frequency
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock (asynchronous to clk)
- mosi  in  1  SPI data in
- cs_n  in  1  SPI chip select, active low
- miso  out  1  SPI data out
- reg_addr  out  4  register address, valid with reg_wr/reg_rd
- reg_wr  out  1  one-cycle write strobe
- reg_wdata  out  DATA_W  write data, valid with reg_wr
- reg_rd  out  1  one-cycle read request
- reg_rdata  in  DATA_W  read data, captured exactly one clk after reg_rd
- busy  out  1  synchronised cs_n active
- frame_err  out  1  one-cycle pulse on a malformed or aborted frame

## Operation
- sclk, mosi, cs_n each pass through a 2-flop synchroniser. SCLK edges are detected from the synchronised value against a delayed copy. Sample edge and shift edge are derived from CPOL/CPHA.
- Frame format: MSB first. Command byte cmd[7:4] = address, cmd[3:0] = opcode. 0x1 = write, 0x2 = read, anything else is illegal. 0x01 and 0x02 therefore address register 0, compatible with the old test port.
- States: IDLE -> CMD (8 sample edges) -> WDATA or RDATA -> DONE.
  - cs_n falling enters CMD with the bit counter cleared.
  - cs_n rising from any state returns to IDLE.
- CMD, after the 8th sample edge:
  - Legal write: go to WDATA.
  - Legal read: pulse reg_rd with reg_addr, capture reg_rdata into the tx shift register 1 clk later, go to RDATA.
  - Illegal opcode or address: pulse frame_err, go to DONE.
- WDATA: shift mosi in on each sample edge. After DATA_W bits, pulse reg_wr with reg_addr/reg_wdata and go to DONE.
- RDATA: on each shift edge, miso <= tx_sr[DATA_W-1] and tx_sr shifts left. The first data bit appears on the first shift edge after the 8th command sample edge. After DATA_W bits, go to DONE.
- DONE: further SCLK edges are ignored and miso = 0.
- miso is 0 outside RDATA and holds the last driven bit until the next shift edge or frame end.
- cs_n rising in CMD (with >= 1 bit received), WDATA or RDATA before completion pulses frame_err. No reg_wr is issued.
- reg_addr and reg_wdata hold their last values between strobes.
- Reset mid-frame aborts immediately with no strobes. The next cs_n falling edge starts a clean frame.

## Timing
- Reset values: miso 0, reg_addr 0, reg_wr 0, reg_wdata 0, reg_rd 0, busy 0, frame_err 0, state IDLE.
- Pin-to-detect latency: 3 clk from an SCLK/CS_N pin edge to internal edge recognition.
- reg_rd asserts 3 clk after the 8th command sample pin edge. reg_rdata is sampled on the next clk. The 4x ratio guarantees the load precedes the first data shift edge.
- reg_wr asserts 3 clk after the final data sample pin edge.
- miso changes 3 clk after each shift pin edge.
- busy follows cs_n with 2 clk latency.
- frame_err asserts 3 clk after the offending cs_n rising edge or the 8th command sample edge.
- Each strobe lasts exactly 1 clk, at most one per frame.

## Test plan
- DATA_W=64, mode 0: write 0x01 then 64 ones -> exactly one reg_wr, reg_addr=0, reg_wdata=0xFFFF_FFFF_FFFF_FFFF, frame_err never asserts.
- Read 0x32 with reg_rdata=0x0123_4567_89AB_CDEF -> one reg_rd, reg_addr=3, miso shows 0x0123456789ABCDEF MSB first over 64 sample edges.
- Write 0x51 with cs_n raised after 40 data bits -> no reg_wr, one frame_err pulse, busy falls 2 clk after cs_n.
- NUM_REGS=8, commands 0x05 and 0x91 -> no reg_wr/reg_rd, frame_err pulse per frame, miso 0 throughout.
- CPOL=1/CPHA=1 instance, write 0x21 with 0xA5A5_A5A5_5A5A_5A5A -> reg_wr, addr 2, matching data; readback via 0x22 returns the same word on miso.
- rst_n pulsed low after 30 data bits of a write -> all outputs 0 immediately, no reg_wr; next full write frame completes correctly.
